// File: rtl/shared_unit_sched_if.sv
// Request, issue and response signals between the requesters, the shared
// execution unit and shared_unit_sched.
// The slave modport is the scheduler side. The master modport is the
// requester/unit side, which the testbench drives.
interface shared_unit_sched_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32
);
  localparam int IdxWidth = $clog2(NumReq);

  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq*DataWidth-1:0] req_data_i;
  logic                        unit_valid_o;
  logic                        unit_ready_i;
  logic [DataWidth-1:0]        unit_data_o;
  logic [IdxWidth-1:0]         unit_tag_o;
  logic                        unit_rsp_valid_i;
  logic                        unit_rsp_ready_o;
  logic [DataWidth-1:0]        unit_rsp_data_i;
  logic [NumReq-1:0]           rsp_valid_o;
  logic [NumReq-1:0]           rsp_ready_i;
  logic [DataWidth-1:0]        rsp_data_o;

  modport slave (
    input  req_valid_i, req_data_i, unit_ready_i, unit_rsp_valid_i,
           unit_rsp_data_i, rsp_ready_i,
    output req_ready_o, unit_valid_o, unit_data_o, unit_tag_o,
           unit_rsp_ready_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_data_i, unit_ready_i, unit_rsp_valid_i,
           unit_rsp_data_i, rsp_ready_i,
    input  req_ready_o, unit_valid_o, unit_data_o, unit_tag_o,
           unit_rsp_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/shared_unit_sched.sv
// Shares one in-order pipelined unit among NumReq requesters.
// A round-robin arbiter chooses which requester issues. A stalled grant
// stays locked until the unit accepts it. An in-order tag FIFO returns each
// response to the requester that issued it. A per-requester credit count
// limits in-flight work. flush_i drains all outstanding work and then resets
// the arbitration priority to index 0.
// Optional: define SHARED_UNIT_SCHED_PERF_EN to add issue/stall counters.
module shared_unit_sched #(
  parameter int NumReq         = 4,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4,
  parameter int CreditsPerReq  = 2,
  parameter int IdxWidth       = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  shared_unit_sched_if.slave   bus,
  output logic                 busy_o
`ifdef SHARED_UNIT_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issue_cnt_o,
  output logic [31:0]          perf_stall_cnt_o
`endif
);

  localparam int CntWidth  = $clog2(CreditsPerReq + 1);
  localparam int PtrWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int FillWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic {StRun, StDrain} state_e;

  state_e                state_q;
  logic [IdxWidth-1:0]   ptr_q;
  logic                  lock_q;
  logic [IdxWidth-1:0]   lock_idx_q;
  logic [CntWidth-1:0]   credit_q [NumReq];
  logic [IdxWidth-1:0]   fifo_q [MaxOutstanding];
  logic [PtrWidth-1:0]   wr_ptr_q;
  logic [PtrWidth-1:0]   rd_ptr_q;
  logic [FillWidth-1:0]  fill_q;

  logic [NumReq-1:0]     eligible;
  logic [IdxWidth-1:0]   winner;
  logic [IdxWidth-1:0]   head;
  logic                  found;
  logic                  full;
  logic                  empty;
  logic                  issue_hs;
  logic                  rsp_ready_int;
  logic                  rsp_hs;
  logic                  drain_done;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign empty      = (fill_q == '0);
  assign full       = (fill_q == FillWidth'(MaxOutstanding));
  assign head       = fifo_q[rd_ptr_q];
  assign issue_hs   = found && bus.unit_ready_i;
  assign rsp_hs     = bus.unit_rsp_valid_i && rsp_ready_int;
  assign drain_done = (state_q == StDrain) && empty && !lock_q;
  assign busy_o     = !empty || (state_q == StDrain);

  // A requester may compete only in RUN, with credit left and FIFO space free.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = bus.req_valid_i[i] && (credit_q[i] < CntWidth'(CreditsPerReq))
                    && !full && (state_q == StRun);
    end
  end

  // Round-robin search upward from the pointer. A held lock overrides the search.
  always_comb begin
    logic [IdxWidth-1:0] cand;
    int sum;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    sum    = 0;
    if (lock_q) begin
      winner = lock_idx_q;
      found  = 1'b1;
    end else begin
      for (int off = 0; off < NumReq; off++) begin
        sum = int'(ptr_q) + off;
        if (sum >= NumReq) sum = sum - NumReq;
        cand = IdxWidth'(sum);
        if (!found && eligible[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  // Present the winner to the unit combinationally and route the head response.
  always_comb begin
    bus.unit_valid_o = found;
    bus.unit_tag_o   = winner;
    bus.unit_data_o  = '0;
    bus.req_ready_o  = '0;
    bus.rsp_valid_o  = '0;
    bus.rsp_data_o   = bus.unit_rsp_data_i;
    rsp_ready_int    = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (winner == IdxWidth'(i)) begin
        bus.unit_data_o    = bus.req_data_i[i*DataWidth +: DataWidth];
        bus.req_ready_o[i] = issue_hs;
      end
      if (!empty && head == IdxWidth'(i)) begin
        bus.rsp_valid_o[i] = bus.unit_rsp_valid_i;
        rsp_ready_int      = bus.rsp_ready_i[i];
      end
    end
    bus.unit_rsp_ready_o = rsp_ready_int;
  end

  // Control FSM together with the priority pointer and the issue lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      case (state_q)
        StRun:   if (flush_i) state_q <= StDrain;
        StDrain: if (drain_done) state_q <= StRun;
        default: state_q <= StRun;
      endcase
      if (issue_hs) begin
        ptr_q <= (winner == IdxWidth'(NumReq - 1)) ? '0 : winner + IdxWidth'(1);
      end else if (drain_done) begin
        ptr_q <= '0;
      end
      if (found && !bus.unit_ready_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= winner;
      end else if (issue_hs) begin
        lock_q <= 1'b0;
      end
    end
  end

  // The tag FIFO records the issuer order, and each credit tracks that requester's in-flight count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
      for (int i = 0; i < NumReq; i++) credit_q[i] <= '0;
    end else begin
      if (issue_hs) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (rsp_hs) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (issue_hs && !rsp_hs) fill_q <= fill_q + FillWidth'(1);
      else if (!issue_hs && rsp_hs) fill_q <= fill_q - FillWidth'(1);
      for (int i = 0; i < NumReq; i++) begin
        if (issue_hs && winner == IdxWidth'(i) && !(rsp_hs && head == IdxWidth'(i)))
          credit_q[i] <= credit_q[i] + CntWidth'(1);
        else if (rsp_hs && head == IdxWidth'(i) && !(issue_hs && winner == IdxWidth'(i)))
          credit_q[i] <= credit_q[i] - CntWidth'(1);
      end
    end
  end

`ifdef SHARED_UNIT_SCHED_PERF_EN
  // Free-running counters for issues and stalled cycles. A flush does not clear them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issue_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (issue_hs) perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
      if (found && !bus.unit_ready_i) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/shared_unit_sched.md
Name: shared_unit_sched

Overview:
- Shares one in-order, pipelined execution unit (e.g. an FPU operation group) between NumReq requesters.
- Arbitrates issue with fair round-robin and holds each decision until the unit accepts it.
- Records each issuer's index in an in-order tag FIFO so every response returns to the requester that issued it.
- Per-requester credit counters cap in-flight operations; a flush state machine drains outstanding work cleanly.

Parameters:
- NumReq, 4: number of requesters, ≥2.
- DataWidth, 32: operation/response payload width in bits.
- MaxOutstanding, 4: total in-flight operations; tag FIFO depth, ≥1.
- CreditsPerReq, 2: max in-flight operations per requester, 1..MaxOutstanding.
- IdxWidth, $clog2(NumReq): requester index width (derived, do not override).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  request drain and priority reset.
- req_valid_i  in  NumReq  per-requester operation valid.
- req_ready_o  out  NumReq  per-requester operation accepted.
- req_data_i  in  NumReq*DataWidth  packed operation payloads; requester i uses slice i.
- unit_valid_o  out  1  issue valid to unit.
- unit_ready_i  in  1  unit accepts issue.
- unit_data_o  out  DataWidth  issued payload.
- unit_tag_o  out  IdxWidth  index of the issuing requester.
- unit_rsp_valid_i  in  1  unit response valid, in issue order.
- unit_rsp_ready_o  out  1  response consumed.
- unit_rsp_data_i  in  DataWidth  response payload.
- rsp_valid_o  out  NumReq  response valid, one-hot.
- rsp_ready_i  in  NumReq  requester accepts response.
- rsp_data_o  out  DataWidth  response payload, broadcast to all requesters.
- busy_o  out  1  tag FIFO non-empty or state is DRAIN.

Behaviour:
- Reset: all outputs 0; state RUN; priority pointer 0; credits 0; FIFO empty; lock clear.
- Eligibility: req_valid_i[i] & credit[i] < CreditsPerReq & FIFO not full & state RUN. No same-cycle pop-to-push bypass on a full FIFO.
- Arbitration: fair round-robin; start search at pointer, pick the next eligible index upward with wrap.
  - On an issue handshake the pointer moves to winner+1, wrapping at NumReq-1 to 0.
- Issue is combinational, zero-cycle: unit_valid_o, unit_data_o and unit_tag_o reflect the winner in the same cycle.
  - req_ready_o[w] = unit_ready_i & unit_valid_o, asserted only for the winner w.
- Lock: if unit_valid_o & !unit_ready_i, register the winner. Next cycle re-present the same index regardless of other requests or eligibility until accepted.
  - Requesters must hold valid/data while unaccepted.
- Issue handshake: push winner index into FIFO and increment credit[w].
- Response routing: head = FIFO head index.
  - rsp_valid_o[head] = unit_rsp_valid_i & !empty.
  - unit_rsp_ready_o = rsp_ready_i[head] & !empty.
  - rsp_data_o = unit_rsp_data_i.
  - On the response handshake, pop the FIFO and decrement credit[head].
- Response with FIFO empty: unit_rsp_ready_o=0 and no rsp_valid_o asserted. This is a protocol violation and is not consumed.
- Simultaneous issue and response for the same requester: its credit count is unchanged. FIFO push and pop in the same cycle are both allowed when not full.
- Credit counter width: $clog2(CreditsPerReq+1). Overflow and underflow cannot occur by construction.
- FSM:
  - RUN: flush_i=1 → DRAIN.
  - DRAIN: no new arbitration. A locked pending issue still completes its handshake (it is pushed/credited normally). Responses continue to drain.
  - DRAIN → RUN when the FIFO is empty and no lock is held; on that transition the pointer resets to 0.
  - flush_i while already in DRAIN has no further effect.
- Async reset mid-operation clears everything immediately. The in-flight unit state is the system's responsibility.

Optional Feature:
SHARED_UNIT_SCHED_PERF_EN
- Defined: adds ports perf_issue_cnt_o (out, 32) and perf_stall_cnt_o (out, 32). Both reset to 0 and wrap at 2^32.
  - perf_issue_cnt_o counts issue handshakes.
  - perf_stall_cnt_o counts cycles with unit_valid_o & !unit_ready_i.
  - flush_i does not clear them.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Round-robin fairness: NumReq=4, all valid held, unit_ready_i=1, fast responses → unit_tag_o sequence 0,1,2,3,0,1…
- Lock-in: req 1 wins with unit_ready_i=0 for 3 cycles, then req 0 raises valid → unit_tag_o stays 1 all 3 cycles; req_ready_o[1] pulses on acceptance, then tag 2 or 0 per pointer.
- Credit cap: CreditsPerReq=2, only req 2 active, no responses → exactly 2 issues, then unit_valid_o=0; one response to req 2 → third issue next cycle.
- Routing: issue order 3,0,3; responses D0,D1,D2 → rsp_valid_o one-hot 1000,0001,1000 with matching rsp_data_o. rsp_ready_i[0]=0 stalls unit_rsp_ready_o.
- FIFO full: MaxOutstanding=4, four issues, no responses → no further issue; busy_o=1.
- Flush: flush_i with 2 outstanding and a locked issue → locked issue accepted, no new issues, RUN resumes after 3 responses; next winner searched from index 0.
